// File: rtl/result_writeback.sv
// rtl/result_writeback.sv - buffers GPU results and writes them to SRAM at consecutive addresses
module result_writeback #(
   parameter int ADDR_WIDTH      = 16,
   parameter int ACC_WIDTH       = 32,
   parameter int ADDR_STRIDE     = 1,
   parameter int FIFO_DEPTH      = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_vld,
   input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
   input  logic [ADDR_WIDTH-1:0] cfg_count,
   input  logic                  res_vld,
   output logic                  res_rdy,
   input  logic [ACC_WIDTH-1:0]  res_data,
   output logic                  w_req_vld,
   input  logic                  w_req_rdy,
   output logic [ADDR_WIDTH-1:0] w_req_addr,
   output logic [ACC_WIDTH-1:0]  w_req_data,
   input  logic                  w_ack_vld,
   output logic                  done,
   output logic                  busy,
   output logic                  ack_err
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [ADDR_WIDTH-1:0] STRIDE  = ADDR_WIDTH'(ADDR_STRIDE);
   localparam logic [OW-1:0]         MAX_OUT = OW'(MAX_OUTSTANDING);
   localparam logic [PW:0]           DEPTH   = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] base;
   logic [ADDR_WIDTH-1:0] count;
   logic [ADDR_WIDTH-1:0] acc_cnt;
   logic [ADDR_WIDTH-1:0] iss_cnt;
   logic [OW-1:0]         outst;
   logic [ACC_WIDTH-1:0]  mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [PW:0]           fifo_cnt;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  push;
   logic                  pop;
   logic                  ack_ok;

   assign fifo_full  = (fifo_cnt == DEPTH);
   assign fifo_empty = (fifo_cnt == '0);

   // Handshake outputs come only from registered state, so they never loop back on valid/ready.
   assign res_rdy    = (state == RUN) && !fifo_full && (acc_cnt < count);
   assign w_req_vld  = ((state == RUN) || (state == DRAIN)) && !fifo_empty && (outst < MAX_OUT);
   assign w_req_data = mem[rd_ptr];
   assign w_req_addr = base + iss_cnt * STRIDE;

   assign push   = res_vld && res_rdy;
   assign pop    = w_req_vld && w_req_rdy;
   assign ack_ok = w_ack_vld && (outst != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         base     <= '0;
         count    <= '0;
         acc_cnt  <= '0;
         iss_cnt  <= '0;
         outst    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         done     <= 1'b0;
         busy     <= 1'b0;
         ack_err  <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         done <= 1'b0;

         if (push) begin
            mem[wr_ptr] <= res_data;
            wr_ptr      <= wr_ptr + PW'(1);
            acc_cnt     <= acc_cnt + ADDR_WIDTH'(1);
         end
         if (pop) begin
            rd_ptr  <= rd_ptr + PW'(1);
            iss_cnt <= iss_cnt + ADDR_WIDTH'(1);
         end

         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
            2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase

         case ({pop, ack_ok})
            2'b10:   outst <= outst + OW'(1);
            2'b01:   outst <= outst - OW'(1);
            default: outst <= outst;
         endcase

         if (w_ack_vld && (outst == '0)) ack_err <= 1'b1;

         case (state)
            IDLE: begin
               if (cfg_vld) begin
                  base    <= cfg_base_addr;
                  count   <= cfg_count;
                  acc_cnt <= '0;
                  iss_cnt <= '0;
                  outst   <= '0;
                  busy    <= 1'b1;
                  state   <= (cfg_count == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               if (acc_cnt == count) state <= DRAIN;
            end
            DRAIN: begin
               // Registered values: an ack arriving with the last issue is already folded into outst.
               if ((iss_cnt == count) && (outst == '0) && fifo_empty) state <= DONE;
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_result_writeback.sv
// tb/tb_result_writeback.sv - scoreboard and vector bench for result_writeback
module tb_result_writeback;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_vld;
   logic [15:0] cfg_base_addr;
   logic [15:0] cfg_count;
   logic        res_vld;
   logic        res_rdy;
   logic [31:0] res_data;
   logic        w_req_vld;
   logic        w_req_rdy;
   logic [15:0] w_req_addr;
   logic [31:0] w_req_data;
   logic        w_ack_vld;
   logic        done;
   logic        busy;
   logic        ack_err;

   result_writeback dut (
      .clk(clk), .rst(rst), .cfg_vld(cfg_vld), .cfg_base_addr(cfg_base_addr),
      .cfg_count(cfg_count), .res_vld(res_vld), .res_rdy(res_rdy), .res_data(res_data),
      .w_req_vld(w_req_vld), .w_req_rdy(w_req_rdy), .w_req_addr(w_req_addr),
      .w_req_data(w_req_data), .w_ack_vld(w_ack_vld), .done(done), .busy(busy),
      .ack_err(ack_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [15:0] base;
      logic [15:0] count;
      logic [31:0] data0;
      logic [15:0] last_addr;
   } vec_t;

   wr_t         exp_q[$];
   logic [31:0] src_q[$];
   vec_t        vecs[4];

   int          total = 0;
   int          bad = 0;
   int          writes = 0;
   int          accepted = 0;
   int          done_cnt = 0;
   logic [15:0] exp_base = '0;
   logic [15:0] last_addr = '0;
   logic        ack_mode = 1'b0;
   logic        issued = 1'b0;
   logic        hold_chk = 1'b0;
   logic [15:0] hold_addr = '0;
   logic [31:0] hold_data = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      wr_t e;
      if (hold_chk) begin
         chk("hold_vld", 32'(w_req_vld), 32'd1);
         chk("hold_addr", 32'(w_req_addr), 32'(hold_addr));
         chk("hold_data", w_req_data, hold_data);
         hold_chk = 1'b0;
      end
      if (w_req_vld && !w_req_rdy) begin
         hold_chk  = 1'b1;
         hold_addr = w_req_addr;
         hold_data = w_req_data;
      end
      if (res_vld && res_rdy) begin
         e.addr = exp_base + 16'(accepted);
         e.data = res_data;
         exp_q.push_back(e);
         void'(src_q.pop_front());
         accepted++;
      end
      if (w_req_vld && w_req_rdy) begin
         writes++;
         issued = 1'b1;
         last_addr = w_req_addr;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected_write: got addr %0h data %0h expected no write", w_req_addr, w_req_data);
         end else begin
            e = exp_q.pop_front();
            if (w_req_addr !== e.addr || w_req_data !== e.data) begin
               bad++;
               $display("FAIL sb_write: got %0h/%0h expected %0h/%0h", w_req_addr, w_req_data, e.addr, e.data);
            end
         end
      end
      if (done) done_cnt++;
   endtask

   task automatic update_auto();
      res_vld  = (src_q.size() != 0);
      res_data = (src_q.size() != 0) ? src_q[0] : 32'h0;
      if (ack_mode) w_ack_vld = issued;
      issued = 1'b0;
   endtask

   task automatic step();
      monitor();
      @(negedge clk);
      update_auto();
   endtask

   task automatic start_job(input logic [15:0] base, input logic [15:0] cnt, input logic [31:0] data0);
      writes   = 0;
      accepted = 0;
      done_cnt = 0;
      exp_base = base;
      for (int i = 0; i < int'(cnt); i++) src_q.push_back(data0 + 32'(i));
      cfg_base_addr = base;
      cfg_count     = cnt;
      cfg_vld       = 1'b1;
      update_auto();
      step();
      cfg_vld = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      int n = 0;
      while (done_cnt == 0 && n < bound) begin
         step();
         n++;
      end
      if (done_cnt == 0) begin
         total++;
         bad++;
         $display("FAIL done_timeout: got no done expected done within %0d cycles", bound);
      end
      for (int i = 0; i < 3; i++) step();
   endtask

   initial begin
      vecs[0] = '{base: 16'h0100, count: 16'd3, data0: 32'hA,         last_addr: 16'h0102};
      vecs[1] = '{base: 16'hFFFE, count: 16'd4, data0: 32'h100,       last_addr: 16'h0001};
      vecs[2] = '{base: 16'h1234, count: 16'd1, data0: 32'hDEADBEEF,  last_addr: 16'h1234};
      vecs[3] = '{base: 16'h0000, count: 16'd5, data0: 32'h55,        last_addr: 16'h0004};

      rst = 1'b1; cfg_vld = 1'b0; cfg_base_addr = '0; cfg_count = '0;
      res_vld = 1'b0; res_data = '0; w_req_rdy = 1'b0; w_ack_vld = 1'b0;
      @(negedge clk);
      chk("rst_res_rdy", 32'(res_rdy), 0);
      chk("rst_w_req_vld", 32'(w_req_vld), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ack_err", 32'(ack_err), 0);
      chk("rst_addr", 32'(w_req_addr), 0);
      chk("rst_data", w_req_data, 0);
      rst = 1'b0;
      step();

      // Table-driven jobs: full-rate ready, ack one cycle after each issue
      ack_mode = 1'b1; w_req_rdy = 1'b1;
      foreach (vecs[v]) begin
         start_job(vecs[v].base, vecs[v].count, vecs[v].data0);
         chk($sformatf("v%0d_busy_run", v), 32'(busy), 1);
         wait_done(200);
         chk($sformatf("v%0d_writes", v), 32'(writes), 32'(vecs[v].count));
         chk($sformatf("v%0d_done_pulses", v), 32'(done_cnt), 1);
         chk($sformatf("v%0d_last_addr", v), 32'(last_addr), 32'(vecs[v].last_addr));
         chk($sformatf("v%0d_busy_after", v), 32'(busy), 0);
         chk($sformatf("v%0d_ack_err", v), 32'(ack_err), 0);
         chk($sformatf("v%0d_sb_left", v), 32'(exp_q.size()), 0);
      end

      // Backpressure: FIFO fills, request held stable
      w_req_rdy = 1'b0;
      start_job(16'h0400, 16'd8, 32'h1000);
      for (int i = 0; i < 20; i++) step();
      chk("bp_accepted", 32'(accepted), 4);
      chk("bp_res_rdy", 32'(res_rdy), 0);
      chk("bp_w_req_vld", 32'(w_req_vld), 1);
      chk("bp_addr", 32'(w_req_addr), 32'h0400);
      w_req_rdy = 1'b1;
      wait_done(200);
      chk("bp_writes", 32'(writes), 8);
      chk("bp_done_pulses", 32'(done_cnt), 1);

      // Outstanding limit: no acks until forced, one ack releases one write
      ack_mode = 1'b0; w_ack_vld = 1'b0;
      start_job(16'h0800, 16'd8, 32'h2000);
      for (int i = 0; i < 20; i++) step();
      chk("os_writes_cap", 32'(writes), 4);
      chk("os_vld_blocked", 32'(w_req_vld), 0);
      for (int k = 0; k < 8; k++) begin
         w_ack_vld = 1'b1;
         step();
         w_ack_vld = 1'b0;
         for (int i = 0; i < 4; i++) step();
         if (k < 4) chk($sformatf("os_release_%0d", k), 32'(writes), 32'(5 + k));
      end
      wait_done(50);
      chk("os_writes", 32'(writes), 8);
      chk("os_ack_err", 32'(ack_err), 0);

      // Zero-length job, then stray ack
      start_job(16'h0500, 16'd0, 32'h0);
      chk("z_done_1", 32'(done), 0);
      chk("z_busy_1", 32'(busy), 1);
      step();
      chk("z_done_2", 32'(done), 1);
      chk("z_busy_2", 32'(busy), 0);
      step();
      chk("z_done_3", 32'(done), 0);
      for (int i = 0; i < 3; i++) step();
      chk("z_no_writes", 32'(writes), 0);
      w_ack_vld = 1'b1;
      step();
      w_ack_vld = 1'b0;
      step();
      chk("z_ack_err", 32'(ack_err), 1);
      for (int i = 0; i < 5; i++) step();
      chk("z_ack_err_sticky", 32'(ack_err), 1);

      // Asynchronous reset with two writes outstanding
      start_job(16'h0200, 16'd8, 32'h3000);
      begin
         int n = 0;
         while (writes < 2 && n < 50) begin step(); n++; end
      end
      chk("ar_writes_before", 32'(writes), 2);
      #2 rst = 1'b1;
      #1;
      chk("ar_res_rdy", 32'(res_rdy), 0);
      chk("ar_w_req_vld", 32'(w_req_vld), 0);
      chk("ar_busy", 32'(busy), 0);
      chk("ar_done", 32'(done), 0);
      chk("ar_ack_err", 32'(ack_err), 0);
      chk("ar_addr", 32'(w_req_addr), 0);
      chk("ar_data", w_req_data, 0);
      @(negedge clk);
      exp_q.delete(); src_q.delete(); hold_chk = 1'b0; issued = 1'b0;
      res_vld = 1'b0; done_cnt = 0;
      step(); step();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("ar_no_done", 32'(done_cnt), 0);
      ack_mode = 1'b1;
      start_job(16'h0300, 16'd2, 32'h4000);
      wait_done(100);
      chk("ar_new_writes", 32'(writes), 2);
      chk("ar_new_last_addr", 32'(last_addr), 32'h0301);
      chk("ar_new_done", 32'(done_cnt), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
